bp_fpga_button_event: RTL and testbench

//  Turns a raw, bouncing, asynchronous push-button into clean "send" events for
//  the FPGA host test system's send FSM (the send_i -> send_lo path).

---
 rtl/bp_fpga_button_event.sv | 149 ++++++++++++++
 tb/tb_bp_fpga_button_event.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_fpga_button_event.sv
// Push-button front end: synchronizer, debounce FSM, optional auto-repeat and a
// valid/yumi event latch that coalesces presses and flags overruns.
module bp_fpga_button_event #(
    parameter int sync_stages_p          = 2,
    parameter int debounce_cycles_p      = 1_000_000,
    parameter int repeat_en_p            = 0,
    parameter int repeat_delay_cycles_p  = 50_000_000,
    parameter int repeat_period_cycles_p = 10_000_000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic level_o,
    output logic v_o,
    input  logic yumi_i,
    output logic overrun_o
);
    // state        | meaning
    // e_idle       | button released and stable, level_o=0
    // e_db_press   | press seen, waiting for debounce_cycles_p stable cycles
    // e_held       | press accepted, level_o=1, repeat timer running if enabled
    // e_db_release | release seen, waiting for stability, repeat timer paused

    if (sync_stages_p < 2) begin : g_bad_sync
        $error("sync_stages_p must be >= 2");
    end
    if (debounce_cycles_p < 1 || repeat_delay_cycles_p < 1 || repeat_period_cycles_p < 1) begin : g_bad_cnt
        $error("cycle count parameters must be >= 1");
    end

    localparam int cnt_w_lp   = $clog2(debounce_cycles_p + 1);
    localparam int rpt_max_lp = (repeat_delay_cycles_p > repeat_period_cycles_p)
                              ? repeat_delay_cycles_p : repeat_period_cycles_p;
    localparam int rpt_w_lp   = $clog2(rpt_max_lp + 1);

    localparam logic [cnt_w_lp-1:0] db_last_lp     = cnt_w_lp'(debounce_cycles_p - 1);
    localparam logic [rpt_w_lp-1:0] rpt_delay_lp   = rpt_w_lp'(repeat_delay_cycles_p - 1);
    localparam logic [rpt_w_lp-1:0] rpt_period_lp  = rpt_w_lp'(repeat_period_cycles_p - 1);

    typedef enum logic [1:0] {
        e_idle,
        e_db_press,
        e_held,
        e_db_release
    } state_e;

    state_e                     r_state;
    logic [sync_stages_p-1:0]   r_sync;
    logic [cnt_w_lp-1:0]        r_cnt;
    logic [rpt_w_lp-1:0]        r_rpt_cnt;
    logic                       r_rpt_first;
    logic                       r_level;
    logic                       r_v;
    logic                       r_overrun;

    logic w_s;
    logic w_db_done;
    logic w_rpt_done;
    logic w_evt;

    assign w_s        = r_sync[sync_stages_p-1];
    assign w_db_done  = (r_cnt == db_last_lp);
    assign w_rpt_done = r_rpt_first ? (r_rpt_cnt == rpt_delay_lp)
                                    : (r_rpt_cnt == rpt_period_lp);
    assign w_evt      = ((r_state == e_db_press) && w_s && w_db_done)
                     || ((r_state == e_held) && w_s && (repeat_en_p != 0) && w_rpt_done);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= e_idle;
            r_sync      <= '0;
            r_cnt       <= '0;
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
            r_level     <= 1'b0;
            r_v         <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync <= {r_sync[sync_stages_p-2:0], btn_i};

            case (r_state)
                e_idle: begin
                    if (w_s) begin
                        r_state <= e_db_press;
                        r_cnt   <= '0;
                    end
                end
                e_db_press: begin
                    if (!w_s) begin
                        r_state <= e_idle;
                        r_cnt   <= '0;
                    end else if (w_db_done) begin
                        r_state     <= e_held;
                        r_cnt       <= '0;
                        r_level     <= 1'b1;
                        r_rpt_cnt   <= '0;
                        r_rpt_first <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                e_held: begin
                    if (!w_s) begin
                        r_state <= e_db_release;
                        r_cnt   <= '0;
                    end else if (repeat_en_p != 0) begin
                        if (w_rpt_done) begin
                            r_rpt_cnt   <= '0;
                            r_rpt_first <= 1'b0;
                        end else begin
                            r_rpt_cnt <= r_rpt_cnt + 1'b1;
                        end
                    end
                end
                e_db_release: begin
                    // a bounce back to pressed resumes the repeat timer where it paused
                    if (w_s) begin
                        r_state <= e_held;
                        r_cnt   <= '0;
                    end else if (w_db_done) begin
                        r_state <= e_idle;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= e_idle;
                    r_cnt   <= '0;
                end
            endcase

            if (w_evt) begin
                r_v <= 1'b1;
                if (r_v && !yumi_i) begin
                    r_overrun <= 1'b1;
                end
            end else if (yumi_i && r_v) begin
                r_v <= 1'b0;
            end
        end
    end

    assign level_o   = r_level;
    assign v_o       = r_v;
    assign overrun_o = r_overrun;

endmodule

// File: tb/tb_bp_fpga_button_event.sv
// Scoreboard bench for bp_fpga_button_event: expected event cycles are queued as
// the button is driven and compared when v_o rises on each instance.
module tb_bp_fpga_button_event;
    logic clk;
    logic rst;
    logic btn0, btn1;
    logic yumi0_drv, tie0;
    logic yumi0, yumi1;
    logic level0, v0, ov0;
    logic level1, v1, ov1;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int q0[$];
    int q1[$];
    logic v0_q = 1'b0;
    logic v1_q = 1'b0;

    assign yumi0 = tie0 ? v0 : yumi0_drv;
    assign yumi1 = v1;

    bp_fpga_button_event #(
        .sync_stages_p(2), .debounce_cycles_p(4), .repeat_en_p(0),
        .repeat_delay_cycles_p(10), .repeat_period_cycles_p(5)
    ) dut0 (
        .clk_i(clk), .reset_i(rst), .btn_i(btn0), .level_o(level0),
        .v_o(v0), .yumi_i(yumi0), .overrun_o(ov0)
    );

    bp_fpga_button_event #(
        .sync_stages_p(2), .debounce_cycles_p(4), .repeat_en_p(1),
        .repeat_delay_cycles_p(10), .repeat_period_cycles_p(5)
    ) dut1 (
        .clk_i(clk), .reset_i(rst), .btn_i(btn1), .level_o(level1),
        .v_o(v1), .yumi_i(yumi1), .overrun_o(ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // event monitor: every rising v_o must match the next queued cycle
    always @(negedge clk) begin
        if (v0 && !v0_q) begin
            if (q0.size() == 0) chk("evt0_unexpected", cyc, -1);
            else chk("evt0_cycle", cyc, q0.pop_front());
        end
        if (v1 && !v1_q) begin
            if (q1.size() == 0) chk("evt1_unexpected", cyc, -1);
            else chk("evt1_cycle", cyc, q1.pop_front());
        end
        v0_q = v0;
        v1_q = v1;
    end

    initial begin
        int a;
        rst = 1'b1; btn0 = 1'b0; btn1 = 1'b0; yumi0_drv = 1'b0; tie0 = 1'b0;
        step(3);
        chk("rst_level0", level0, 0);
        chk("rst_v0", v0, 0);
        chk("rst_ov0", ov0, 0);
        chk("rst_level1", level1, 0);
        chk("rst_v1", v1, 0);
        chk("rst_ov1", ov1, 0);
        rst = 1'b0;

        // clean press with yumi tied to v_o, no repeat
        tie0 = 1'b1;
        step(2);
        btn0 = 1'b1;
        q0.push_back(cyc + 7);
        step(3);
        chk("t1_level_early", level0, 0);
        step(3);
        chk("t1_level_pre", level0, 0);
        step(1);
        chk("t1_level_rise", level0, 1);
        step(13);
        btn0 = 1'b0;
        step(6);
        chk("t1_level_hold", level0, 1);
        step(1);
        chk("t1_level_fall", level0, 0);
        step(5);

        // bounce 1,0,1,0 then held
        btn0 = 1'b1; step(1);
        btn0 = 1'b0; step(1);
        btn0 = 1'b1; step(1);
        btn0 = 1'b0; step(1);
        btn0 = 1'b1;
        q0.push_back(cyc + 7);
        step(4);
        chk("t2_level_bounce", level0, 0);
        chk("t2_v_bounce", v0, 0);
        step(3);
        chk("t2_level_rise", level0, 1);
        chk("t2_overrun", ov0, 0);
        step(5);
        btn0 = 1'b0;
        step(12);

        // two presses without consumer: coalesce and overrun
        tie0 = 1'b0; yumi0_drv = 1'b0;
        btn0 = 1'b1;
        q0.push_back(cyc + 7);
        step(10);
        btn0 = 1'b0;
        step(12);
        chk("t3_v_pending", v0, 1);
        chk("t3_ov_first", ov0, 0);
        btn0 = 1'b1;
        step(6);
        chk("t3_ov_before", ov0, 0);
        step(1);
        chk("t3_ov_set", ov0, 1);
        chk("t3_v_still", v0, 1);
        step(3);
        btn0 = 1'b0;
        step(12);
        yumi0_drv = 1'b1;
        step(1);
        yumi0_drv = 1'b0;
        chk("t3_v_taken", v0, 0);
        chk("t3_ov_sticky", ov0, 1);

        rst = 1'b1;
        step(1);
        chk("rst2_ov0", ov0, 0);
        chk("rst2_v0", v0, 0);
        step(1);
        rst = 1'b0;

        // event coinciding with yumi keeps v_o high
        btn0 = 1'b1;
        q0.push_back(cyc + 7);
        step(10);
        btn0 = 1'b0;
        step(12);
        chk("t5_pending", v0, 1);
        btn0 = 1'b1;
        step(6);
        yumi0_drv = 1'b1;
        step(1);
        yumi0_drv = 1'b0;
        chk("t5_coincide_v", v0, 1);
        chk("t5_coincide_ov", ov0, 0);
        step(1);
        chk("t5_still_v", v0, 1);
        yumi0_drv = 1'b1;
        step(1);
        yumi0_drv = 1'b0;
        chk("t5_taken", v0, 0);
        btn0 = 1'b0;
        step(12);

        // auto-repeat on instance 1
        btn1 = 1'b1;
        a = cyc + 7;
        q1.push_back(a);
        for (int k = 10; k <= 35; k += 5) q1.push_back(a + k);
        step(43);
        btn1 = 1'b0;
        step(15);
        chk("t4_level_off", level1, 0);
        chk("t4_overrun", ov1, 0);

        // reset mid-debounce and mid-held with button kept down
        tie0 = 1'b1;
        btn0 = 1'b1;
        step(4);
        rst = 1'b1;
        step(1);
        chk("t6a_level", level0, 0);
        chk("t6a_v", v0, 0);
        chk("t6a_ov", ov0, 0);
        rst = 1'b0;
        q0.push_back(cyc + 7);
        step(7);
        chk("t6a_level_rise", level0, 1);
        step(3);
        rst = 1'b1;
        step(1);
        chk("t6b_level", level0, 0);
        chk("t6b_v", v0, 0);
        rst = 1'b0;
        q0.push_back(cyc + 7);
        step(7);
        chk("t6b_level_rise", level0, 1);
        step(2);
        btn0 = 1'b0;
        step(12);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
